step_dir_monitor: RTL and testbench

// - APB3 responder that reads back the step/dir pulse streams produced by stepper_control (or motor-side feedback pins).
// - Per axis: synchronises step/dir, detects rising step edges, keeps a signed position and an unsigned total-step count.
// - Flags direction-setup violations and position overflow.
// - Sits on a CoreAPB3 slot next to stepper_control, so firmware can close the loop on commanded versus executed steps.

---
 rtl/step_dir_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_step_dir_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_monitor.sv
// step_dir_monitor: APB3 responder that watches two step/dir pulse streams.
// Each axis synchronises its step and dir pins, counts rising step edges into a
// signed position and an unsigned total-step count, and flags direction-setup
// violations and position overflow. A level interrupt is raised from the
// status flags that firmware has enabled in CTRL.

module step_dir_monitor #(
    parameter int POS_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DIR_SETUP   = 2
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        step1_in,
    input  logic        dir1_in,
    input  logic        step2_in,
    input  logic        dir2_in,
    output logic        irq
);

    // The stable counter only has to reach DIR_SETUP, so size it for that value.
    localparam int SCNT_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
    localparam logic [SCNT_W-1:0] SETUP_MAX = SCNT_W'(DIR_SETUP);
    localparam logic [POS_W-1:0]  POS_MAX   = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0]  POS_MIN   = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

    // Register offsets as seen on PADDR[4:2].
    localparam logic [2:0] IDX_POS1   = 3'd0;
    localparam logic [2:0] IDX_POS2   = 3'd1;
    localparam logic [2:0] IDX_STATUS = 3'd2;
    localparam logic [2:0] IDX_CTRL   = 3'd3;
    localparam logic [2:0] IDX_CNT1   = 3'd4;
    localparam logic [2:0] IDX_CNT2   = 3'd5;

    // Raw pins packed so both axes can share the same loop bodies.
    logic [1:0] step_pin;
    logic [1:0] dir_pin;

    logic [SYNC_STAGES-1:0] step_sync [2];
    logic [SYNC_STAGES-1:0] dir_sync  [2];

    logic [1:0] s_step;
    logic [1:0] s_step_q;
    logic [1:0] s_dir;
    logic [1:0] s_dir_q;
    logic [1:0] step_edge;
    logic [1:0] dir_changed;
    logic [1:0] dir_eff;
    logic [1:0] setup_bad;
    logic [1:0] ovf_hit;
    logic [1:0] count_edge;
    logic [3:0] flag_set;

    logic [SCNT_W-1:0] stable_cnt [2];
    logic [POS_W-1:0]  pos        [2];
    logic [POS_W-1:0]  cnt        [2];
    logic [3:0]        status;
    logic [7:0]        ctrl;

    // APB decode signals.
    logic       access;
    logic       addr_hi_ok;
    logic [2:0] idx;
    logic       mapped;
    logic       wr;
    logic [1:0] wr_pos;
    logic [1:0] wr_cnt;
    logic       wr_status;
    logic       wr_ctrl;
    logic [31:0] rd_data;

    // Address bits outside the decoded window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, PADDR[31:8], PADDR[1:0]};

    assign step_pin = {step2_in, step1_in};
    assign dir_pin  = {dir2_in, dir1_in};

    assign access     = PSEL & PENABLE;
    assign addr_hi_ok = (PADDR[7:5] == 3'd0);
    assign idx        = PADDR[4:2];
    assign mapped     = addr_hi_ok & (idx <= IDX_CNT2);
    assign wr         = access & PWRITE & mapped;
    assign wr_pos     = {wr & (idx == IDX_POS2), wr & (idx == IDX_POS1)};
    assign wr_cnt     = {wr & (idx == IDX_CNT2), wr & (idx == IDX_CNT1)};
    assign wr_status  = wr & (idx == IDX_STATUS);
    assign wr_ctrl    = wr & (idx == IDX_CTRL);

    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;
    assign PRDATA  = rd_data;

    // Bring the asynchronous step and dir pins into the PCLK domain.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            for (int a = 0; a < 2; a++) begin
                step_sync[a] <= '0;
                dir_sync[a]  <= '0;
            end
        end else begin
            for (int a = 0; a < 2; a++) begin
                step_sync[a] <= {step_sync[a][SYNC_STAGES-2:0], step_pin[a]};
                dir_sync[a]  <= {dir_sync[a][SYNC_STAGES-2:0], dir_pin[a]};
            end
        end
    end

    // Per-axis edge detection, direction, setup and overflow qualification.
    always_comb begin
        s_step      = '0;
        s_dir       = '0;
        step_edge   = '0;
        dir_changed = '0;
        dir_eff     = '0;
        setup_bad   = '0;
        ovf_hit     = '0;
        count_edge  = '0;
        flag_set    = '0;
        for (int a = 0; a < 2; a++) begin
            s_step[a]      = step_sync[a][SYNC_STAGES-1];
            s_dir[a]       = dir_sync[a][SYNC_STAGES-1];
            step_edge[a]   = s_step[a] & ~s_step_q[a];
            dir_changed[a] = s_dir[a] ^ s_dir_q[a];
            dir_eff[a]     = s_dir[a] ^ ctrl[2+a];
            // A dir change coincident with the edge has zero stable time.
            setup_bad[a]   = dir_changed[a] | (stable_cnt[a] < SETUP_MAX);
            ovf_hit[a]     = dir_eff[a] ? (pos[a] == POS_MAX) : (pos[a] == POS_MIN);
            // A firmware write to this axis' POS or CNT swallows a coincident edge.
            count_edge[a]  = step_edge[a] & ctrl[a] & ~(wr_pos[a] | wr_cnt[a]);
            flag_set[a]    = count_edge[a] & ovf_hit[a];
            flag_set[2+a]  = count_edge[a] & setup_bad[a];
        end
    end

    // Edge history and dir-stable counters keep tracking even on a disabled axis.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            s_step_q <= '0;
            s_dir_q  <= '0;
            for (int a = 0; a < 2; a++) begin
                stable_cnt[a] <= '0;
            end
        end else begin
            s_step_q <= s_step;
            s_dir_q  <= s_dir;
            for (int a = 0; a < 2; a++) begin
                if (dir_changed[a]) begin
                    stable_cnt[a] <= '0;
                end else if (stable_cnt[a] < SETUP_MAX) begin
                    stable_cnt[a] <= stable_cnt[a] + SCNT_ONE;
                end
            end
        end
    end

    // Position (wrapping) and total-step count (saturating), with APB writes taking priority.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            for (int a = 0; a < 2; a++) begin
                pos[a] <= '0;
                cnt[a] <= '0;
            end
        end else begin
            for (int a = 0; a < 2; a++) begin
                if (wr_pos[a]) begin
                    pos[a] <= PWDATA[POS_W-1:0];
                end else if (count_edge[a]) begin
                    pos[a] <= dir_eff[a] ? (pos[a] + POS_ONE) : (pos[a] - POS_ONE);
                end
                if (wr_cnt[a]) begin
                    cnt[a] <= '0;
                end else if (count_edge[a] && (cnt[a] != '1)) begin
                    cnt[a] <= cnt[a] + POS_ONE;
                end
            end
        end
    end

    // Sticky status flags: write-one-to-clear, with a new set beating a clear.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            status <= '0;
        end else if (wr_status) begin
            status <= (status & ~PWDATA[3:0]) | flag_set;
        end else begin
            status <= status | flag_set;
        end
    end

    // Control register: enables, direction inversion and interrupt enables.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            ctrl <= 8'h03;
        end else if (wr_ctrl) begin
            ctrl <= PWDATA[7:0];
        end
    end

    // Registered interrupt so it follows the flag by one cycle.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status & ctrl[7:4]);
        end
    end

    // Read mux: zero outside a selected, mapped offset; narrow registers zero-extend.
    always_comb begin
        rd_data = '0;
        if (PSEL && mapped) begin
            case (idx)
                IDX_POS1:   rd_data[POS_W-1:0] = pos[0];
                IDX_POS2:   rd_data[POS_W-1:0] = pos[1];
                IDX_STATUS: rd_data[3:0]       = status;
                IDX_CTRL:   rd_data[7:0]       = ctrl;
                IDX_CNT1:   rd_data[POS_W-1:0] = cnt[0];
                IDX_CNT2:   rd_data[POS_W-1:0] = cnt[1];
                default:    rd_data            = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_step_dir_monitor.sv
// tb_step_dir_monitor: directed scenarios for step_dir_monitor with
// hand-computed expected register values.

module tb_step_dir_monitor;

    logic        PCLK;
    logic        PRESERN;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        step1_in;
    logic        dir1_in;
    logic        step2_in;
    logic        dir2_in;
    logic        irq;

    int errors = 0;
    int checks = 0;

    step_dir_monitor dut (
        .PCLK     (PCLK),
        .PRESERN  (PRESERN),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .step1_in (step1_in),
        .dir1_in  (dir1_in),
        .step2_in (step2_in),
        .dir2_in  (dir2_in),
        .irq      (irq)
    );

    // 100 MHz-style free-running clock.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic err, output logic rdy);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        tick(1);
        PENABLE = 1'b1;
        #3;
        data = PRDATA; err = PSLVERR; rdy = PREADY;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Pulses of 3 cycles high / 3 cycles low on the selected axis.
    task automatic pulse_steps(input int axis, input int n);
        for (int i = 0; i < n; i++) begin
            if (axis == 1) step1_in = 1'b1; else step2_in = 1'b1;
            tick(3);
            if (axis == 1) step1_in = 1'b0; else step2_in = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic err, rdy;
        logic [31:0] exp_vals [6];
        exp_vals = '{32'h0, 32'h0, 32'h0, 32'h3, 32'h0, 32'h0};
        PRESERN = 1'b0;
        tick(3);
        checks++;
        if (irq !== 1'b0 || PRDATA !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs irq=%b prdata=%h want irq=0 prdata=0", irq, PRDATA);
        end
        PRESERN = 1'b1;
        tick(3);
        for (int i = 0; i < 6; i++) begin
            apb_read(32'(i * 4), rd, err, rdy);
            checks++;
            if (rd !== exp_vals[i] || err !== 1'b0 || rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_read_%0h got=%h err=%b rdy=%b want=%h err=0 rdy=1",
                         i * 4, rd, err, rdy, exp_vals[i]);
            end
        end
    endtask

    task automatic test_count_up_down();
        logic [31:0] rd;
        logic err, rdy;
        dir1_in = 1'b1;
        tick(10);
        pulse_steps(1, 5);
        tick(5);
        apb_read(32'h00, rd, err, rdy); checks++;
        if (rd !== 32'd5) begin errors++; $display("[TB] FAIL pos1_up got=%h want=%h", rd, 32'd5); end
        apb_read(32'h10, rd, err, rdy); checks++;
        if (rd !== 32'd5) begin errors++; $display("[TB] FAIL cnt1_up got=%h want=%h", rd, 32'd5); end
        apb_read(32'h08, rd, err, rdy); checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL status_up got=%h want=0", rd); end
        dir1_in = 1'b0;
        tick(10);
        pulse_steps(1, 7);
        tick(5);
        apb_read(32'h00, rd, err, rdy); checks++;
        if (rd !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL pos1_down got=%h want=fffffffe", rd); end
        apb_read(32'h10, rd, err, rdy); checks++;
        if (rd !== 32'd12) begin errors++; $display("[TB] FAIL cnt1_down got=%h want=%h", rd, 32'd12); end
        apb_read(32'h08, rd, err, rdy); checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL status_down got=%h want=0", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic err, rdy;
        apb_write(32'h04, 32'h7FFF_FFFF);
        dir2_in = 1'b1;
        tick(10);
        pulse_steps(2, 1);
        tick(5);
        apb_read(32'h04, rd, err, rdy); checks++;
        if (rd !== 32'h8000_0000) begin errors++; $display("[TB] FAIL pos2_wrap got=%h want=80000000", rd); end
        apb_read(32'h08, rd, err, rdy); checks++;
        if (rd !== 32'h2) begin errors++; $display("[TB] FAIL status_ovf2 got=%h want=2", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked got=%b want=0", irq); end
        apb_write(32'h08, 32'h2);
        apb_read(32'h08, rd, err, rdy); checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL status_w1c got=%h want=0", rd); end
    endtask

    task automatic test_setup_violation();
        logic [31:0] rd;
        logic err, rdy;
        apb_write(32'h0C, 32'h43);
        tick(2);
        dir1_in = 1'b1;
        tick(1);
        step1_in = 1'b1;
        tick(3);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_early got=%b want=0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_delayed got=%b want=1", irq); end
        tick(2);
        step1_in = 1'b0;
        tick(4);
        apb_read(32'h08, rd, err, rdy); checks++;
        if (rd !== 32'h4) begin errors++; $display("[TB] FAIL status_serr1 got=%h want=4", rd); end
        apb_read(32'h00, rd, err, rdy); checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL pos1_serr got=%h want=ffffffff", rd); end
        apb_read(32'h10, rd, err, rdy); checks++;
        if (rd !== 32'd13) begin errors++; $display("[TB] FAIL cnt1_serr got=%h want=%h", rd, 32'd13); end
        apb_write(32'h08, 32'h4);
        tick(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_cleared got=%b want=0", irq); end
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        logic err, rdy;
        apb_write(32'h0C, 32'h01);
        pulse_steps(2, 4);
        tick(5);
        apb_read(32'h04, rd, err, rdy); checks++;
        if (rd !== 32'h8000_0000) begin errors++; $display("[TB] FAIL pos2_disabled got=%h want=80000000", rd); end
        apb_read(32'h14, rd, err, rdy); checks++;
        if (rd !== 32'd1) begin errors++; $display("[TB] FAIL cnt2_disabled got=%h want=1", rd); end
        step2_in = 1'b1;
        tick(5);
        apb_write(32'h0C, 32'h03);
        tick(3);
        step2_in = 1'b0;
        tick(5);
        apb_read(32'h14, rd, err, rdy); checks++;
        if (rd !== 32'd1) begin errors++; $display("[TB] FAIL cnt2_reenable_high got=%h want=1", rd); end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        logic err, rdy;
        tick(2);
        step1_in = 1'b1;
        tick(1);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'd100;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        tick(3);
        step1_in = 1'b0;
        tick(5);
        apb_read(32'h00, rd, err, rdy); checks++;
        if (rd !== 32'd100) begin errors++; $display("[TB] FAIL pos1_write_wins got=%h want=%h", rd, 32'd100); end
        apb_write(32'h14, 32'hDEAD_BEEF);
        apb_read(32'h14, rd, err, rdy); checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL cnt2_clear got=%h want=0", rd); end
    endtask

    task automatic test_slverr();
        logic [31:0] rd;
        logic err, rdy;
        apb_read(32'h18, rd, err, rdy); checks++;
        if (rd !== 32'h0 || err !== 1'b1 || rdy !== 1'b1) begin
            errors++; $display("[TB] FAIL slverr_18 got=%h err=%b rdy=%b want=0 err=1 rdy=1", rd, err, rdy);
        end
        apb_read(32'h80, rd, err, rdy); checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            errors++; $display("[TB] FAIL slverr_80 got=%h err=%b want=0 err=1", rd, err);
        end
        apb_write(32'h18, 32'hFFFF_FFFF);
        apb_read(32'h00, rd, err, rdy); checks++;
        if (rd !== 32'd100 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL pos1_after_bad_wr got=%h err=%b want=%h err=0", rd, err, 32'd100);
        end
        apb_read(32'h0C, rd, err, rdy); checks++;
        if (rd !== 32'h3) begin errors++; $display("[TB] FAIL ctrl_after_bad_wr got=%h want=3", rd); end
        apb_read(32'h08, rd, err, rdy); checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL status_after_bad_wr got=%h want=0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic err, rdy;
        PRESERN = 1'b0;
        tick(2);
        PRESERN = 1'b1;
        tick(2);
        apb_read(32'h00, rd, err, rdy); checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL pos1_mid_reset got=%h want=0", rd); end
        apb_read(32'h04, rd, err, rdy); checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL pos2_mid_reset got=%h want=0", rd); end
        apb_read(32'h0C, rd, err, rdy); checks++;
        if (rd !== 32'h3) begin errors++; $display("[TB] FAIL ctrl_mid_reset got=%h want=3", rd); end
    endtask

    // Scenario sequence; each task leaves the bench just after a rising edge.
    initial begin
        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        step1_in = 1'b0; dir1_in = 1'b0; step2_in = 1'b0; dir2_in = 1'b0;
        #1;
        test_reset();
        test_count_up_down();
        test_overflow();
        test_setup_violation();
        test_disable();
        test_collision();
        test_slverr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
